// File: rtl/sysbus_rr_arbiter.sv
// Round-robin burst arbiter sharing the 64-bit memory bus between
// instruction fetch (port 0) and data access (port 1).
module sysbus_rr_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reqcyc0,
  output logic                      reqack0,
  input  logic [BUS_DATA_WIDTH-1:0] req0,
  input  logic [BUS_TAG_WIDTH-1:0]  reqtag0,
  output logic                      respcyc0,
  input  logic                      respack0,
  output logic [BUS_DATA_WIDTH-1:0] resp0,
  output logic [BUS_TAG_WIDTH-1:0]  resptag0,
  input  logic                      reqcyc1,
  output logic                      reqack1,
  input  logic [BUS_DATA_WIDTH-1:0] req1,
  input  logic [BUS_TAG_WIDTH-1:0]  reqtag1,
  output logic                      respcyc1,
  input  logic                      respack1,
  output logic [BUS_DATA_WIDTH-1:0] resp1,
  output logic [BUS_TAG_WIDTH-1:0]  resptag1,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      owner,
  output logic                      busy
);

  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE, ADDR, WDATA, RRESP
  } state_t;

  state_t                     state, state_n;
  logic [BW-1:0]              beat, beat_n;
  logic                       owner_q, owner_n;
  logic                       last_q, last_n;
  logic [BUS_TAG_WIDTH-1:0]   tag_q, tag_n;

  logic                       own_cyc;
  logic [BUS_DATA_WIDTH-1:0]  own_req;
  logic [BUS_TAG_WIDTH-1:0]   own_tag;
  logic                       own_respack;
  logic                       req_hs;
  logic                       resp_hs;

  assign own_cyc     = owner_q ? reqcyc1 : reqcyc0;
  assign own_req     = owner_q ? req1 : req0;
  assign own_tag     = owner_q ? reqtag1 : reqtag0;
  assign own_respack = owner_q ? respack1 : respack0;
  assign req_hs      = own_cyc & bus_reqack;
  assign resp_hs     = bus_respcyc & own_respack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      beat    <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      tag_q   <= '0;
    end else begin
      state   <= state_n;
      beat    <= beat_n;
      owner_q <= owner_n;
      last_q  <= last_n;
      tag_q   <= tag_n;
    end
  end

  always_comb begin
    state_n = state;
    beat_n  = beat;
    owner_n = owner_q;
    last_n  = last_q;
    tag_n   = tag_q;
    unique case (state)
      IDLE: begin
        if (reqcyc0 | reqcyc1) begin
          // on a tie the port that lost last time wins
          owner_n = (reqcyc0 & reqcyc1) ? ~last_q : reqcyc1;
          last_n  = owner_n;
          state_n = ADDR;
        end
      end
      ADDR: begin
        if (req_hs) begin
          tag_n   = own_tag;
          beat_n  = '0;
          state_n = own_tag[BUS_TAG_WIDTH-1] ? WDATA : RRESP;
        end
      end
      WDATA: begin
        if (req_hs) begin
          if (beat == LAST) begin
            beat_n  = '0;
            state_n = IDLE;
          end else begin
            beat_n = beat + 1'b1;
          end
        end
      end
      RRESP: begin
        if (resp_hs) begin
          if (beat == LAST) begin
            beat_n  = '0;
            state_n = IDLE;
          end else begin
            beat_n = beat + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    reqack0     = 1'b0;
    reqack1     = 1'b0;
    respcyc0    = 1'b0;
    respcyc1    = 1'b0;
    resp0       = '0;
    resp1       = '0;
    resptag0    = '0;
    resptag1    = '0;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    unique case (state)
      ADDR, WDATA: begin
        bus_reqcyc = own_cyc;
        bus_req    = own_req;
        bus_reqtag = (state == ADDR) ? own_tag : tag_q;
        reqack0    = ~owner_q & bus_reqack;
        reqack1    = owner_q & bus_reqack;
      end
      RRESP: begin
        bus_respack = own_respack;
        if (owner_q) begin
          respcyc1 = bus_respcyc;
          resp1    = bus_resp;
          resptag1 = bus_resptag;
        end else begin
          respcyc0 = bus_respcyc;
          resp0    = bus_resp;
          resptag0 = bus_resptag;
        end
      end
      default: ;
    endcase
  end

  assign owner = owner_q;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_sysbus_rr_arbiter.sv
// Bench for sysbus_rr_arbiter: grant table plus scoreboarded
// read/write bursts, stalls, stray responses and mid-burst reset.
module tb_sysbus_rr_arbiter;

  logic        clk;
  logic        reset;
  logic        reqcyc0, reqack0, respcyc0, respack0;
  logic        reqcyc1, reqack1, respcyc1, respack1;
  logic [63:0] req0, req1, resp0, resp1;
  logic [12:0] reqtag0, reqtag1, resptag0, resptag1;
  logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0] bus_req, bus_resp;
  logic [12:0] bus_reqtag, bus_resptag;
  logic        owner, busy;

  sysbus_rr_arbiter dut (
    .clk(clk), .reset(reset),
    .reqcyc0(reqcyc0), .reqack0(reqack0),
    .req0(req0), .reqtag0(reqtag0),
    .respcyc0(respcyc0), .respack0(respack0),
    .resp0(resp0), .resptag0(resptag0),
    .reqcyc1(reqcyc1), .reqack1(reqack1),
    .req1(req1), .reqtag1(reqtag1),
    .respcyc1(respcyc1), .respack1(respack1),
    .resp1(resp1), .resptag1(resptag1),
    .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
    .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .owner(owner), .busy(busy)
  );

  typedef struct {
    logic [63:0] d;
    logic [12:0] t;
  } beat_t;

  typedef struct {
    logic r0;
    logic r1;
    logic o;
  } vec_t;

  beat_t bq[$];
  beat_t rq0[$];
  beat_t rq1[$];
  beat_t em;
  vec_t  vt[9];

  int checks = 0;
  int errors = 0;
  int bus_beats = 0;
  int ack1_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int p, input logic c,
                           input logic [63:0] d, input logic [12:0] t);
    if (p == 0) begin
      reqcyc0 = c; req0 = d; reqtag0 = t;
    end else begin
      reqcyc1 = c; req1 = d; reqtag1 = t;
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? reqack0 : reqack1;
  endfunction

  task automatic send_beat(input int p, input logic [63:0] d,
                           input logic [12:0] t, input logic [12:0] et);
    beat_t b;
    int n;
    b.d = d;
    b.t = et;
    bq.push_back(b);
    drive_req(p, 1'b1, d, t);
    #1;
    n = 0;
    while (!ack_of(p) && n < 20) begin
      tick();
      n++;
    end
    chk("ack_wait", 64'(n < 20), 64'd1);
    tick();
  endtask

  task automatic resp_beats(input int p, input logic [63:0] base,
                            input logic [12:0] t);
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      bus_respcyc = 1'b1;
      bus_resp    = base + 64'(i);
      bus_resptag = t;
      b.d = base + 64'(i);
      b.t = t;
      if (p == 0) begin
        respack0 = 1'b1;
        rq0.push_back(b);
      end else begin
        respack1 = 1'b1;
        rq1.push_back(b);
      end
      #1;
      chk("respcyc", (p == 0) ? respcyc0 : respcyc1, 64'd1);
      tick();
    end
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    respack0    = 1'b0;
    respack1    = 1'b0;
    #1;
    chk("idle_after_read", busy, 64'd0);
  endtask

  task automatic reset_dut;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus_reqcyc && bus_reqack) begin
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_beat got %0h want none", bus_req);
        end else begin
          em = bq.pop_front();
          chk("bus_req", bus_req, em.d);
          chk("bus_reqtag", 64'(bus_reqtag), 64'(em.t));
          bus_beats++;
        end
      end
      if (reqcyc1 && reqack1) ack1_cnt++;
      if (respcyc0) begin
        if (rq0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL respcyc0 got 1 want 0");
        end else if (respack0) begin
          em = rq0.pop_front();
          chk("resp0", resp0, em.d);
          chk("resptag0", 64'(resptag0), 64'(em.t));
        end
      end
      if (respcyc1) begin
        if (rq1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL respcyc1 got 1 want 0");
        end else if (respack1) begin
          em = rq1.pop_front();
          chk("resp1", resp1, em.d);
          chk("resptag1", 64'(resptag1), 64'(em.t));
        end
      end
    end
  end

  initial begin
    int nb;
    vt[0] = '{1'b1, 1'b1, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b1};
    vt[2] = '{1'b1, 1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b1};
    vt[4] = '{1'b1, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b0, 1'b0};
    vt[6] = '{1'b1, 1'b1, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b1};
    vt[8] = '{1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    drive_req(0, 1'b0, '0, '0);
    drive_req(1, 1'b0, '0, '0);
    respack0 = 1'b0;
    respack1 = 1'b0;
    bus_reqack = 1'b1;
    bus_respcyc = 1'b0;
    bus_resp = '0;
    bus_resptag = '0;
    reset_dut();

    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_bus_reqcyc", bus_reqcyc, 0);
    chk("rst_reqack", {reqack1, reqack0}, 0);
    chk("rst_respcyc", {respcyc1, respcyc0}, 0);

    // single read from port 0
    send_beat(0, 64'h100, 13'h0005, 13'h0005);
    drive_req(0, 1'b0, '0, '0);
    #1;
    chk("rd0_owner", owner, 0);
    chk("rd0_busy", busy, 1);
    resp_beats(0, 64'h10, 13'h0005);

    // stray response while idle
    bus_respcyc = 1'b1;
    bus_resp = 64'hbad;
    respack0 = 1'b1;
    respack1 = 1'b1;
    #1;
    chk("stray_respack", bus_respack, 0);
    chk("stray_respcyc", {respcyc1, respcyc0}, 0);
    tick();
    bus_respcyc = 1'b0;
    bus_resp = '0;
    respack0 = 1'b0;
    respack1 = 1'b0;
    #1;

    // single write from port 1
    ack1_cnt = 0;
    send_beat(1, 64'h1000, 13'h1001, 13'h1001);
    for (int i = 0; i < 8; i++)
      send_beat(1, 64'hA0 + 64'(i), 13'h0, 13'h1001);
    drive_req(1, 1'b0, '0, '0);
    #1;
    chk("wr1_idle", busy, 0);
    chk("wr1_acks", 64'(ack1_cnt), 64'd9);

    // write from port 0 with bus stall and requester gap
    nb = bus_beats;
    send_beat(0, 64'h2000, 13'h1002, 13'h1002);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        bus_reqack = 1'b0;
        drive_req(0, 1'b1, 64'hdead, 13'h0);
        repeat (3) tick();
        chk("stall_busy", busy, 1);
        chk("stall_ack", reqack0, 0);
        chk("stall_cyc", bus_reqcyc, 1);
        bus_reqack = 1'b1;
        drive_req(0, 1'b0, '0, '0);
        repeat (2) tick();
        chk("gap_busy", busy, 1);
        chk("gap_cyc", bus_reqcyc, 0);
      end
      send_beat(0, 64'hB0 + 64'(i), 13'h0, 13'h1002);
    end
    drive_req(0, 1'b0, '0, '0);
    #1;
    chk("stall_idle", busy, 0);
    chk("stall_beats", 64'(bus_beats - nb), 64'd9);

    // grant table from reset
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      beat_t b;
      drive_req(0, vt[i].r0, 64'h3000 + 64'(i), 13'h0);
      drive_req(1, vt[i].r1, 64'h4000 + 64'(i), 13'h0);
      b.d = (vt[i].o ? 64'h4000 : 64'h3000) + 64'(i);
      b.t = 13'h0;
      bq.push_back(b);
      tick();
      chk("tbl_busy", busy, 1);
      chk("tbl_owner", owner, 64'(vt[i].o));
      chk("tbl_ack", ack_of(int'(vt[i].o)), 1);
      tick();
      drive_req(0, 1'b0, '0, '0);
      drive_req(1, 1'b0, '0, '0);
      resp_beats(int'(vt[i].o), 64'h300 + 64'(i * 16), 13'h0);
    end

    // reset in the middle of a port 1 write
    send_beat(1, 64'h5000, 13'h1003, 13'h1003);
    for (int i = 0; i < 4; i++)
      send_beat(1, 64'hC0 + 64'(i), 13'h0, 13'h1003);
    drive_req(1, 1'b1, 64'hC4, 13'h0);
    #1;
    reset = 1'b1;
    drive_req(1, 1'b0, '0, '0);
    tick();
    reset = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_owner", owner, 0);
    chk("mrst_bus_reqcyc", bus_reqcyc, 0);
    chk("mrst_bus_req", bus_req, 0);
    chk("mrst_bus_reqtag", 64'(bus_reqtag), 0);
    chk("mrst_reqack", {reqack1, reqack0}, 0);
    send_beat(1, 64'h6000, 13'h00AA, 13'h00AA);
    drive_req(1, 1'b0, '0, '0);
    #1;
    chk("rd1_owner", owner, 1);
    resp_beats(1, 64'h70, 13'h00AA);

    repeat (2) tick();
    chk("bq_empty", 64'(bq.size()), 0);
    chk("rq0_empty", 64'(rq0.size()), 0);
    chk("rq1_empty", 64'(rq1.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysbus_rr_arbiter.md
# sysbus_rr_arbiter

Round-robin, burst-aware arbiter that shares the single 64-bit system memory bus between the instruction-fetch requester (port 0) and the data-access requester (port 1). It grants the bus to one requester per transaction and streams request, write-data and read-response beats straight through, with no line buffering. The bus stays locked to the owner until the full 8-beat burst completes. It sits between the two cache-side bus masters and the DRAM bus interface.

## Interface
- BUS_DATA_WIDTH, 64, width of request/response data beats
- BUS_TAG_WIDTH, 13, width of request/response tags; bit [BUS_TAG_WIDTH-1] = 1 means write, 0 means read
- BEATS, 8, data beats per line (write data beats or read response beats)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- reqcyc0 / reqcyc1  in  1  requester n drives a valid beat on reqN/reqtagN
- reqack0 / reqack1  out  1  beat accepted from requester n
- req0 / req1  in  BUS_DATA_WIDTH  address beat, then write data beats
- reqtag0 / reqtag1  in  BUS_TAG_WIDTH  transaction tag, sampled on the address beat
- respcyc0 / respcyc1  out  1  response beat valid to requester n
- respack0 / respack1  in  1  requester n accepts the response beat
- resp0 / resp1  out  BUS_DATA_WIDTH  response data
- resptag0 / resptag1  out  BUS_TAG_WIDTH  response tag
- bus_reqcyc  out  1  request beat valid to memory
- bus_reqack  in  1  memory accepts the request beat
- bus_req  out  BUS_DATA_WIDTH  request beat to memory
- bus_reqtag  out  BUS_TAG_WIDTH  request tag to memory
- bus_respcyc  in  1  memory response beat valid
- bus_respack  out  1  response beat accepted
- bus_resp  in  BUS_DATA_WIDTH  memory response data
- bus_resptag  in  BUS_TAG_WIDTH  memory response tag
- owner  out  1  requester currently granted; valid when busy=1
- busy  out  1  a transaction is in progress (state != IDLE)

## Operation
- States: IDLE, ADDR, WDATA, RRESP.
- IDLE: no acks and no bus activity. Arbitration:
  - Only one reqcyc high: grant that requester.
  - Both high: grant the requester that is not last_grant.
  - On grant: set owner to the granted requester, set last_grant to owner, go to ADDR.
- ADDR: combinational pass-through from the owner.
  - bus_reqcyc = reqcycN; bus_req = reqN; bus_reqtag = reqtagN; reqackN = bus_reqack.
  - On handshake (reqcycN & bus_reqack): latch the tag write bit. Write goes to WDATA with beat=0; read goes to RRESP with beat=0.
- WDATA: same pass-through, with bus_reqtag = the latched tag.
  - Each handshake increments beat.
  - Handshake with beat == BEATS-1 goes to IDLE.
- RRESP: pass-through in the response direction.
  - respcycN = bus_respcyc; respN = bus_resp; resptagN = bus_resptag; bus_respack = respackN.
  - Each beat where bus_respcyc & respackN are both high increments beat.
  - Last beat goes to IDLE.
- Non-owner outputs: reqack, respcyc, resp and resptag are 0 at all times. bus_* outputs are 0 outside the pass-through states.
- Owner deasserts reqcyc mid-burst: bus_reqcyc = 0, beat does not advance, state holds. No timeout.
- bus_respcyc in IDLE, ADDR or WDATA: ignored; bus_respack = 0.
- beat is a 3-bit counter (clog2(BEATS)). It never wraps past BEATS-1 within a burst and is cleared on entry to WDATA/RRESP.

## Timing
- Reset values:
  - state = IDLE; beat = 0; owner = 0; last_grant = 1, so port 0 wins the first tie.
  - All outputs 0.
- Reset asserted mid-burst: next cycle is IDLE with all outputs 0. The partial burst is abandoned; requesters must re-issue.
- Grant latency: reqcyc high in IDLE at cycle t gives ADDR at t+1, and the earliest reqack is at t+1.
- Pass-through paths are purely combinational, with zero added latency per beat. One beat per cycle is sustained.
- Turnaround: after the final beat the FSM is in IDLE for at least 1 cycle before the next grant.
- Read: 1 address beat + BEATS response beats. Write: 1 address beat + BEATS data beats.

## Test plan
- Single read, port 0: reqcyc0 with tag bit12=0, memory returns 8 beats 0x10..0x17 → resp0 carries 0x10..0x17 in order, busy drops after the 8th beat, respcyc1 stays 0 throughout.
- Single write, port 1: address 0x1000 with tag bit12=1, then data 0xA0..0xA7 → bus_req carries 0x1000, 0xA0..0xA7; reqack1 is high 9 times; return to IDLE.
- Simultaneous requests after reset → port 0 is granted first and port 1 immediately after. Repeating the tie alternates the grant 0,1,0,1.
- Stalls: bus_reqack low for 3 cycles mid-write, and owner reqcyc dropped 2 cycles → beat count unchanged and exactly 8 data beats reach memory.
- Stray bus_respcyc in IDLE → bus_respack = 0 and no respcyc to either port.
- Reset asserted at write beat 4 → next cycle busy = 0 and all outputs 0. A fresh read from port 1 then completes normally.
